// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared display types and segment constants for the stopwatch.
package stopwatch_pkg;
  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;
  typedef logic [1:0] digit_sel_t;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: active-low BCD to seven-segment decoder, non-BCD shows a dash.
module bcd_to_7seg
  import stopwatch_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: 4-digit multiplexed 7-seg driver with per-frame digit snapshot.
// Optional LEADING_BLANK_EN darkens the leftmost digit when it is zero.
module sevenseg_scan
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int CW = $clog2(TICKS_PER_DIGIT);
  logic [CW-1:0] div_cnt;
  digit_sel_t    sel;
  bcd_t          shadow [4];
  logic          first;
  logic          tick;
  logic          dark;
  seg_t          glyph;
  assign tick = div_cnt == CW'(TICKS_PER_DIGIT - 1);
  bcd_to_7seg u_dec (.bcd(shadow[sel]), .seg(glyph));
`ifdef LEADING_BLANK_EN
  assign dark = (sel == 2'd3) && (shadow[3] == 4'd0);
`else
  assign dark = 1'b0;
`endif
  // shadow reloads only at the frame boundary (or right after reset) so a frame is coherent
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      sel     <= '0;
      shadow  <= '{default: '0};
      first   <= 1'b1;
      an      <= 4'hF;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      sel     <= sel + digit_sel_t'(tick);
      if (first || (tick && sel == 2'd3)) shadow <= '{d0, d1, d2, d3};
      first   <= 1'b0;
      an      <= dark ? 4'hF : ~(4'b0001 << sel);
      seg     <= glyph;
      dp      <= dark | ~sel[0];
    end
  end
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: table-driven check of scan order, decode, dp, snapshot and reset.
module tb_sevenseg_scan;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  int checks = 0;
  int errs = 0;

  typedef struct {
    logic [3:0] d3, d2, d1, d0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t tbl [15];

  sevenseg_scan #(.TICKS_PER_DIGIT(4)) dut (
    .clk(clk), .reset(reset), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] a3, a2, a1, a0, input logic [3:0] e_an,
                              input logic [6:0] e_seg, input logic e_dp);
    mk = '{d3: a3, d2: a2, d1: a1, d0: a0, an: e_an, seg: e_seg, dp: e_dp};
  endfunction

  task automatic chk(input string nm, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    checks += 4;
    if (an !== e_an) begin errs++; $display("FAIL %s an: got %b want %b", nm, an, e_an); end
    if (seg !== e_seg) begin errs++; $display("FAIL %s seg: got %b want %b", nm, seg, e_seg); end
    if (dp !== e_dp) begin errs++; $display("FAIL %s dp: got %b want %b", nm, dp, e_dp); end
    if ($countones(~an) > 1) begin errs++; $display("FAIL %s onehot: got an=%b want at most one low", nm, an); end
  endtask

  task automatic slot(input string nm, input int n, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk(nm, e_an, e_seg, e_dp);
    end
  endtask

  initial begin
    tbl[0]  = mk(4'd1, 4'd2, 4'd3, 4'd4, 4'b1101, 7'b0110000, 1'b0);
    tbl[1]  = mk(4'd1, 4'd2, 4'd3, 4'd7, 4'b1011, 7'b0100100, 1'b1);
    tbl[2]  = mk(4'd1, 4'd2, 4'd3, 4'd7, 4'b0111, 7'b1111001, 1'b0);
    tbl[3]  = mk(4'd1, 4'hC, 4'd3, 4'd7, 4'b1110, 7'b1111000, 1'b1);
    tbl[4]  = mk(4'd1, 4'hC, 4'd3, 4'd7, 4'b1101, 7'b0110000, 1'b0);
    tbl[5]  = mk(4'd1, 4'hC, 4'd3, 4'd7, 4'b1011, 7'b0100100, 1'b1);
    tbl[6]  = mk(4'd0, 4'hC, 4'd3, 4'd7, 4'b0111, 7'b1111001, 1'b0);
    tbl[7]  = mk(4'd0, 4'hC, 4'd3, 4'd7, 4'b1110, 7'b1111000, 1'b1);
    tbl[8]  = mk(4'd0, 4'hC, 4'd3, 4'd7, 4'b1101, 7'b0110000, 1'b0);
    tbl[9]  = mk(4'd0, 4'hC, 4'd3, 4'd7, 4'b1011, 7'b0111111, 1'b1);
`ifdef LEADING_BLANK_EN
    tbl[10] = mk(4'd2, 4'd5, 4'd3, 4'd7, 4'b1111, 7'b1000000, 1'b1);
`else
    tbl[10] = mk(4'd2, 4'd5, 4'd3, 4'd7, 4'b0111, 7'b1000000, 1'b0);
`endif
    tbl[11] = mk(4'd2, 4'd5, 4'd3, 4'd7, 4'b1110, 7'b1111000, 1'b1);
    tbl[12] = mk(4'd2, 4'd5, 4'd3, 4'd7, 4'b1101, 7'b0110000, 1'b0);
    tbl[13] = mk(4'd2, 4'd5, 4'd3, 4'd7, 4'b1011, 7'b0010010, 1'b1);
    tbl[14] = mk(4'd2, 4'd5, 4'd3, 4'd7, 4'b0111, 7'b0100100, 1'b0);

    reset = 1'b1;
    {d3, d2, d1, d0} = {4'd1, 4'd2, 4'd3, 4'd4};
    repeat (3) @(negedge clk);
    chk("reset", 4'hF, 7'h7F, 1'b1);
    reset = 1'b0;
    slot("release", 1, 4'b1110, 7'b1000000, 1'b1);
    slot("first_d0", 3, 4'b1110, 7'b0011001, 1'b1);
    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("row%0d", r), tbl[r].an, tbl[r].seg, tbl[r].dp);
        if (k == 0) {d3, d2, d1, d0} = {tbl[r].d3, tbl[r].d2, tbl[r].d1, tbl[r].d0};
      end
    end

    slot("pre_rst_s0", 4, 4'b1110, 7'b1111000, 1'b1);
    slot("pre_rst_s1", 4, 4'b1101, 7'b0110000, 1'b0);
    slot("pre_rst_s2", 1, 4'b1011, 7'b0010010, 1'b1);
    {d3, d2, d1, d0} = {4'd9, 4'd5, 4'd8, 4'd6};
    reset = 1'b1;
    slot("mid_reset", 1, 4'hF, 7'h7F, 1'b1);
    reset = 1'b0;
    slot("re_release", 1, 4'b1110, 7'b1000000, 1'b1);
    slot("re_s0", 3, 4'b1110, 7'b0000010, 1'b1);
    slot("re_s1", 4, 4'b1101, 7'b0000000, 1'b0);
    slot("re_s2", 4, 4'b1011, 7'b0010010, 1'b1);
    slot("re_s3", 4, 4'b0111, 7'b0010000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
